// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I boot loader: word width, host command
// encodings, loader FSM states and memory-select values.
package rv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_SETADDR = 2'd0,
    OP_WRITE   = 2'd1,
    OP_READ    = 2'd2,
    OP_RUN     = 2'd3
  } ld_op_e;

  typedef enum logic [1:0] {
    LD_LOAD = 2'd0,
    LD_RESP = 2'd1,
    LD_RUN  = 2'd2
  } ld_state_e;

  localparam logic SEL_IMEM = 1'b0;
  localparam logic SEL_DMEM = 1'b1;

endpackage

// File: rtl/ld_addr_ptr.sv
// Wrap-around byte-address pointer for one memory. A load with a misaligned
// value is refused (pointer holds); an aligned but out-of-range value is
// reduced modulo the memory span. load_err flags either problem on load_val.
module ld_addr_ptr #(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int WORDS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_en,
  input  logic [XLEN-1:0] load_val,
  input  logic            inc_en,
  output logic [XLEN-1:0] ptr,
  output logic            load_err
);

  // Pointer only needs enough bits to address the span; the upper bits are
  // always zero, which gives the wrap for free.
  localparam int AW = $clog2(WORDS * 4);
  localparam logic [XLEN-1:0] SPAN = XLEN'(WORDS * 4);

  logic [AW-1:0] ptr_q, ptr_d;
  logic          misaligned;

  assign misaligned = (load_val[1:0] != 2'b00);
  assign load_err   = misaligned | (load_val >= SPAN);

  // Next pointer: aligned load, else word increment, else hold.
  always_comb begin
    ptr_d = ptr_q;
    if (load_en && !misaligned) begin
      ptr_d = load_val[AW-1:0];
    end else if (inc_en) begin
      ptr_d = ptr_q + AW'(4);
    end
  end

  // Pointer register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = {{(XLEN - AW){1'b0}}, ptr_q};

endmodule

// File: rtl/rv_mem_loader.sv
// Boot-time loader and data-memory port arbiter for the RV32I core. While in
// LOAD/RESP the host fills or reads back imem/dmem through auto-incrementing
// pointers and the core is held in reset; RUN releases the core and hands it
// the dmem port.
//
// Handshakes: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; a response transfers on a rising edge where
// rsp_valid and rsp_ready are both high. rsp_valid/rsp_data stay stable until
// that transfer, and the host must hold its command stable while cmd_valid is
// high and cmd_ready is low.
module rv_mem_loader #(
  parameter int XLEN       = rv_pkg::XLEN,
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic            cmd_sel,
  input  logic [XLEN-1:0] cmd_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            addr_err,
  output logic            running,
  output logic            cpu_reset,
  input  logic            cpu_we,
  input  logic [XLEN-1:0] cpu_addr,
  input  logic [XLEN-1:0] cpu_wdata,
  output logic            imem_we,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [1:0]      dbg_state
);

  import rv_pkg::*;

  ld_state_e       state_q, state_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            addr_err_q, addr_err_d;

  ld_op_e          op;
  logic            fire;
  logic            ld_sel, inc_sel, sel_we;
  logic            sel_err;
  logic [XLEN-1:0] sel_rdata;
  logic [XLEN-1:0] ptr_imem, ptr_dmem;
  logic            err_imem, err_dmem;

  assign op        = ld_op_e'(cmd_op);
  assign cmd_ready = (state_q != LD_RESP);
  assign fire      = cmd_valid & cmd_ready;
  assign sel_rdata = (cmd_sel == SEL_DMEM) ? dmem_rdata : imem_rdata;
  assign sel_err   = (cmd_sel == SEL_DMEM) ? err_dmem : err_imem;

  ld_addr_ptr #(.XLEN(XLEN), .WORDS(IMEM_WORDS)) u_ptr_imem (
    .clk      (clk),
    .reset    (reset),
    .load_en  (ld_sel & (cmd_sel == SEL_IMEM)),
    .load_val (cmd_data),
    .inc_en   (inc_sel & (cmd_sel == SEL_IMEM)),
    .ptr      (ptr_imem),
    .load_err (err_imem)
  );

  ld_addr_ptr #(.XLEN(XLEN), .WORDS(DMEM_WORDS)) u_ptr_dmem (
    .clk      (clk),
    .reset    (reset),
    .load_en  (ld_sel & (cmd_sel == SEL_DMEM)),
    .load_val (cmd_data),
    .inc_en   (inc_sel & (cmd_sel == SEL_DMEM)),
    .ptr      (ptr_dmem),
    .load_err (err_dmem)
  );

  // Command decode and FSM next state; only LOAD touches memories/pointers.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    addr_err_d  = addr_err_q;
    ld_sel      = 1'b0;
    inc_sel     = 1'b0;
    sel_we      = 1'b0;
    case (state_q)
      LD_LOAD: begin
        if (fire) begin
          case (op)
            OP_SETADDR: begin
              ld_sel     = 1'b1;
              addr_err_d = addr_err_q | sel_err;
            end
            OP_WRITE: begin
              // Reset must suppress the combinational strobe too.
              sel_we  = ~reset;
              inc_sel = 1'b1;
            end
            OP_READ: begin
              rsp_data_d  = sel_rdata;
              rsp_valid_d = 1'b1;
              inc_sel     = 1'b1;
              state_d     = LD_RESP;
            end
            OP_RUN: begin
              state_d = LD_RUN;
            end
            default: ;
          endcase
        end
      end
      LD_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = LD_LOAD;
        end
      end
      LD_RUN: begin
        if (fire && op == OP_RUN) begin
          state_d = LD_LOAD;
        end
      end
      default: state_d = LD_LOAD;
    endcase
  end

  // Memory port steering: loader pointers while loading, core owns dmem in RUN.
  always_comb begin
    imem_we    = 1'b0;
    imem_addr  = ptr_imem;
    imem_wdata = '0;
    dmem_we    = 1'b0;
    dmem_addr  = ptr_dmem;
    dmem_wdata = '0;
    if (state_q == LD_RUN) begin
      dmem_we    = cpu_we;
      dmem_addr  = cpu_addr;
      dmem_wdata = cpu_wdata;
    end else if (cmd_sel == SEL_IMEM) begin
      imem_we    = sel_we;
      imem_wdata = cmd_data;
    end else begin
      dmem_we    = sel_we;
      dmem_wdata = cmd_data;
    end
  end

  // Loader state registers; reset wins over any command in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LD_LOAD;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign addr_err  = addr_err_q;
  assign running   = (state_q == LD_RUN);
  assign cpu_reset = (state_q != LD_RUN);
  assign dbg_state = state_q;

endmodule

// File: doc/rv_mem_loader.md
Name: rv_mem_loader

Overview:
- Boot-time memory loader and port arbiter for the RV32I single-cycle core.
- Provides a valid/ready command port that preloads both instruction memory and data memory word-by-word, with address auto-increment and readback.
- Holds the core in reset while loading. Hands the data-memory port back to the core on a RUN command.
- Sits between the core, the writable instr_mem and data_mem, and the external host/testbench.

Parameters:
- XLEN, 32, data/word width.
- IMEM_WORDS, 64, instruction memory depth in words (power of 2).
- DMEM_WORDS, 64, data memory depth in words (power of 2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  loader accepts command this cycle
- cmd_op  in  2  0=SETADDR, 1=WRITE, 2=READ, 3=RUN/STOP
- cmd_sel  in  1  target memory: 0=imem, 1=dmem
- cmd_data  in  XLEN  address (SETADDR) or write data (WRITE)
- rsp_valid  out  1  read response valid
- rsp_ready  in  1  host accepts response
- rsp_data  out  XLEN  read data
- addr_err  out  1  sticky flag: SETADDR address out of range or misaligned
- running  out  1  core released (RUN state)
- cpu_reset  out  1  reset to riscv_cpu
- cpu_we, cpu_addr[XLEN], cpu_wdata[XLEN]  in  core data-memory request
- imem_we  out  1; imem_addr  out  XLEN; imem_wdata  out  XLEN; imem_rdata  in  XLEN
- dmem_we  out  1; dmem_addr  out  XLEN; dmem_wdata  out  XLEN; dmem_rdata  in  XLEN

Behaviour:
- States:
  - LOAD: reset state; cpu_reset=1; loader owns both memories.
  - RESP: read response pending.
  - RUN: cpu_reset=0; dmem driven by the core.
- Reset (any state, incl. mid-read or RUN): state=LOAD, ptr_i=ptr_d=0, addr_err=0, rsp_valid=0, rsp_data=0, running=0, cpu_reset=1, imem_we=dmem_we=0.
- Two byte-address pointers, ptr_i and ptr_d; cmd_sel picks the pointer used.
- cmd_ready=1 in LOAD and RUN; 0 in RESP. A command fires when cmd_valid && cmd_ready.
- LOAD, SETADDR:
  - ptr_sel <= cmd_data[1:0]==0 ? cmd_data : ptr_sel.
  - addr_err <= 1 if misaligned or cmd_data >= WORDS*4. Out-of-range address is masked to cmd_data mod (WORDS*4).
- LOAD, WRITE:
  - Same-cycle combinational write strobe: sel_we=1, sel_addr=ptr_sel, sel_wdata=cmd_data.
  - Memory captures on that clk edge. Then ptr_sel <= ptr_sel+4.
  - Wraps at WORDS*4 -> 0.
- LOAD, READ:
  - rsp_data <= sel_rdata (combinational memory read at ptr_sel).
  - rsp_valid <= 1; ptr_sel += 4 with wrap; state -> RESP.
- RESP: hold rsp_data/rsp_valid until rsp_ready=1. Then rsp_valid <= 0, state -> LOAD (1 cycle later cmd_ready=1).
- LOAD, RUN/STOP: state -> RUN; cpu_reset=0 from the next cycle; running=1.
- In RUN:
  - Only op 3 acts: state -> LOAD, cpu_reset=1 next cycle, pointers unchanged.
  - Other ops are accepted and ignored (no memory side effects).
- Memory muxing:
  - In LOAD/RESP, imem_addr=ptr_i and dmem_addr=ptr_d, except the selected memory, which follows the command.
  - In RUN: imem_we=0; dmem_we/addr/wdata = cpu_we/cpu_addr/cpu_wdata. The core always reads imem via its own PC path (imem is dual-port: write port here).
- Simultaneous reset and a command: reset wins; the command is not performed.
- Back-to-back WRITEs at one per cycle are sustained. READ throughput is at most one per 2 cycles.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN.
  - Op encodings OP_SETADDR/OP_WRITE/OP_READ/OP_RUN.
  - State enum LD_LOAD/LD_RESP/LD_RUN.
  - SEL_IMEM/SEL_DMEM.
- One natural sub-module: ld_addr_ptr, a parametrised wrap-around byte pointer with load, increment and range check, instantiated twice.

Test Plan:
- Reset, then SETADDR imem 0x0; WRITE 0x00500113, 0x00C00193 -> imem words 0,1 hold the values, ptr_i=0x8, cpu_reset=1, cmd_ready=1 each cycle.
- SETADDR dmem 0x10; READ with rsp_ready held low 3 cycles -> rsp_valid stays 1, rsp_data stable = dmem[4], cmd_ready=0 until the cycle after the rsp_ready handshake.
- dmem pointer at 0xFC (DMEM_WORDS=64), WRITE 0xA5A5A5A5 twice -> words 63 then 0 written, ptr_d=0x4.
- SETADDR imem 0x102 -> addr_err=1 sticky, ptr_i unchanged; SETADDR 0x200 -> addr_err stays 1, ptr_i=0x0.
- RUN -> next cycle cpu_reset=0, running=1, dmem_addr follows cpu_addr; a WRITE command is ignored; STOP -> cpu_reset=1 the cycle after.
- Assert reset while in RESP -> rsp_valid=0, state LOAD, pointers 0, addr_err 0 on the next edge.
